// File: rtl/i2c_pcf8574_target.sv
// I2C target that mirrors a PCF8574-style 8-bit quasi-bidirectional port.
// Writes latch into port_out, reads return port_in; the SDA pad is open-drain and lives outside.
`timescale 1ns/1ps
module i2c_pcf8574_target #(
  parameter logic [6:0] ADDR       = 7'h27,
  parameter logic [7:0] PORT_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       wr_stb,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StIgnore
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] port_out_q, port_out_d;
  logic       wr_stb_q, wr_stb_d;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    port_out_d  = port_out_q;
    wr_stb_d    = 1'b0;

    if (start_det) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (stop_det) begin
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
        end
        StAddr, StWrite: begin
          if (scl_rise) begin
            shift_d     = {shift_q[6:0], sda_sync_q};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_done_q) begin
            // byte_done separates the 8th-bit falling edge from the one right after START
            byte_done_d = 1'b0;
            if (state_q == StWrite) begin
              sda_oe_d   = 1'b1;
              port_out_d = shift_q;
              wr_stb_d   = 1'b1;
              state_d    = StWriteAck;
            end else if (shift_q[7:1] == ADDR) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = StAddrAck;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              shift_d  = port_in;
              sda_oe_d = ~port_in[7];
              state_d  = StRead;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrite;
            end
          end
        end
        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWrite;
          end
        end
        StRead: begin
          if (scl_rise) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = StReadAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StReadAck: begin
          if (scl_rise) begin
            ack_d = sda_sync_q;
          end else if (scl_fall) begin
            if (!ack_q) begin
              shift_d  = port_in;
              sda_oe_d = ~port_in[7];
              state_d  = StRead;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StIgnore;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ack_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      port_out_q  <= PORT_RESET;
      wr_stb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      port_out_q  <= port_out_d;
      wr_stb_q    <= wr_stb_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign port_out = port_out_q;
  assign wr_stb   = wr_stb_q;

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// Directed bench for i2c_pcf8574_target: bit-banged initiator on an open-drain SDA model.
`timescale 1ns/1ps
module tb_i2c_pcf8574_target;

  localparam int T = 100;  // quarter SCL period: 10 clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] port_in = 8'hA5;
  logic [7:0] port_out;
  logic       wr_stb;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_pcf8574_target #(.ADDR(7'h27), .PORT_RESET(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .port_in  (port_in),
    .port_out (port_out),
    .wr_stb   (wr_stb),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_stb) wr_cnt <= wr_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #T;
    scl = 1'b1;   #T;
    sda_m = 1'b0; #T;
    scl = 1'b0;   #T;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #T;
    scl = 1'b1;   #T;
    sda_m = 1'b1; #T;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #T;
    scl = 1'b1; #(2*T);
    scl = 1'b0; #T;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; #T;
    scl = 1'b1;   #T;
    ack = sda_bus; #T;
    scl = 1'b0;   #T;
  endtask

  task automatic recv_byte(input logic nack, input logic chg, input logic [7:0] newv,
                           output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #T; scl = 1'b1;
      #T; b = {b[6:0], sda_bus};
      if (chg && i == 3) port_in = newv;
      #T; scl = 1'b0;
      #T;
    end
    sda_m = nack; #T;
    scl = 1'b1;   #(2*T);
    scl = 1'b0;
    sda_m = 1'b1; #T;
  endtask

  logic       ack;
  logic [7:0] rd;
  int         wr_base, oe_base;
  logic [7:0] addr_bits;

  initial begin
    // Reset state
    #25;
    chk("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_wr_stb", {7'd0, wr_stb}, 8'h00);
    chk("rst_port_out", port_out, 8'hFF);
    #30 rst = 1'b0;
    #(2*T);

    // Foreign address 0x20: never ACKed, nothing written
    wr_base = wr_cnt; oe_base = oe_cnt;
    i2c_start();
    send_byte(8'h40, ack); chk("other_addr_nack", {7'd0, ack}, 8'h01);
    send_byte(8'h55, ack); chk("other_data_nack", {7'd0, ack}, 8'h01);
    i2c_stop();
    chk("other_oe_never", 8'(oe_cnt - oe_base), 8'h00);
    chk("other_port_out", port_out, 8'hFF);
    chk("other_no_stb", 8'(wr_cnt - wr_base), 8'h00);

    // Single write 0x3C
    wr_base = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack); chk("wr_addr_ack", {7'd0, ack}, 8'h00);
    chk("wr_busy_high", {7'd0, busy}, 8'h01);
    send_byte(8'h3C, ack); chk("wr_data_ack", {7'd0, ack}, 8'h00);
    i2c_stop();
    chk("wr_port_out", port_out, 8'h3C);
    chk("wr_one_stb", 8'(wr_cnt - wr_base), 8'h01);
    chk("wr_busy_low", {7'd0, busy}, 8'h00);

    // Read two bytes; port_in changes during the first, which was already captured
    port_in = 8'hA5;
    i2c_start();
    send_byte(8'h4F, ack); chk("rd_addr_ack", {7'd0, ack}, 8'h00);
    recv_byte(1'b0, 1'b1, 8'h5A, rd); chk("rd_byte0", rd, 8'hA5);
    recv_byte(1'b1, 1'b0, 8'h00, rd); chk("rd_byte1", rd, 8'h5A);
    chk("rd_oe_after_nack", {7'd0, sda_oe}, 8'h00);
    chk("rd_bus_released", {7'd0, sda_bus}, 8'h01);
    i2c_stop();

    // Write, repeated START, read
    wr_base = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack); chk("rs_addr_ack", {7'd0, ack}, 8'h00);
    send_byte(8'h12, ack); chk("rs_data_ack", {7'd0, ack}, 8'h00);
    i2c_start();
    send_byte(8'h4F, ack); chk("rs_raddr_ack", {7'd0, ack}, 8'h00);
    recv_byte(1'b1, 1'b0, 8'h00, rd); chk("rs_read", rd, 8'h5A);
    i2c_stop();
    chk("rs_port_out", port_out, 8'h12);
    chk("rs_one_stb", 8'(wr_cnt - wr_base), 8'h01);
    chk("rs_busy_low", {7'd0, busy}, 8'h00);

    // Partial byte then STOP: discarded
    wr_base = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack); chk("part_addr_ack", {7'd0, ack}, 8'h00);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    chk("part_port_out", port_out, 8'h12);
    chk("part_no_stb", 8'(wr_cnt - wr_base), 8'h00);
    chk("part_busy_low", {7'd0, busy}, 8'h00);

    // Reset during the address ACK
    i2c_start();
    addr_bits = 8'h4E;
    for (int i = 7; i >= 0; i--) write_bit(addr_bits[i]);
    sda_m = 1'b1; #T;
    chk("mid_oe_before_rst", {7'd0, sda_oe}, 8'h01);
    rst = 1'b1; #1;
    chk("mid_oe_async", {7'd0, sda_oe}, 8'h00);
    chk("mid_port_out", port_out, 8'hFF);
    chk("mid_busy", {7'd0, busy}, 8'h00);
    #20 rst = 1'b0;
    scl = 1'b1; #(2*T);
    scl = 1'b0; #T;
    i2c_stop();
    wr_base = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack); chk("post_addr_ack", {7'd0, ack}, 8'h00);
    send_byte(8'h99, ack); chk("post_data_ack", {7'd0, ack}, 8'h00);
    i2c_stop();
    chk("post_port_out", port_out, 8'h99);
    chk("post_one_stb", 8'(wr_cnt - wr_base), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
